// File: rtl/step_ctrl_if.sv
// step_ctrl_if: bundles the run/step controller's signals into one port.
//   tick        : one-cycle pulse from the slow clock-enable divider
//   btn_run     : raw run/halt toggle button (asynchronous, active-high)
//   btn_step    : raw single-step button (asynchronous, active-high)
//   cpu_halted  : CPU has executed HALT (synchronous level)
//   cpu_en      : one-cycle advance pulse to the CPU
//   running     : high while the controller is free-running
//   step_count  : number of cpu_en pulses issued since reset (wraps)
// The master side drives tick/buttons/cpu_halted; the slave side is the controller.
interface step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             tick;
    logic             btn_run;
    logic             btn_step;
    logic             cpu_halted;
    logic             cpu_en;
    logic             running;
    logic [CNT_W-1:0] step_count;

    modport master (
        output tick, btn_run, btn_step, cpu_halted,
        input  cpu_en, running, step_count
    );

    modport slave (
        input  tick, btn_run, btn_step, cpu_halted,
        output cpu_en, running, step_count
    );
endinterface

// File: rtl/step_ctrl.sv
// step_ctrl: run/step controller for the minicpu.
// Consumes the divider tick and two raw push-buttons and issues one-cycle
// cpu_en pulses: free-running at tick rate (RUN), halted (HALT) or a single
// instruction per step-button press (STEP). Counts issued pulses for display.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : step_ctrl_if.slave (tick, buttons, cpu_halted in; cpu_en,
//          running, step_count out, all outputs registered)
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a button level (>= 2)
//   CNT_W           : width of step_count
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic         clk,
    input  logic         rst,
    step_ctrl_if.slave   bus
);

    localparam int            DW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

    // Index 0 = run button, index 1 = step button.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {bus.btn_step, bus.btn_run};

    // ------------------------------------------------------------------
    // Button conditioning: synchronizer, debouncer, rising-edge pulse.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_q;
            logic          s2_q;
            logic          db_q;
            logic          db_d;
            logic          db_dly_q;
            logic          press_q;
            logic          press_d;
            logic [DW-1:0] dcnt_q;
            logic [DW-1:0] dcnt_d;

            always_comb begin
                db_d   = db_q;
                dcnt_d = dcnt_q;
                if (s2_q == db_q) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DCNT_MAX) begin
                    db_d   = s2_q;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
                // Edge detect on the registered debounced level, so the
                // press pulse appears one edge after db itself changes.
                press_d = db_q & ~db_dly_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q  <= 1'b0;
                    s2_q     <= 1'b0;
                    db_q     <= 1'b0;
                    db_dly_q <= 1'b0;
                    dcnt_q   <= '0;
                    press_q  <= 1'b0;
                end else begin
                    sync1_q  <= btn_raw[gi];
                    s2_q     <= sync1_q;
                    db_q     <= db_d;
                    db_dly_q <= db_q;
                    dcnt_q   <= dcnt_d;
                    press_q  <= press_d;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    logic run_press;
    logic step_press;

    assign run_press  = press[0];
    assign step_press = press[1];

    // ------------------------------------------------------------------
    // Run/step FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             running_q;
    logic             running_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            S_HALT: begin
                // A halted CPU swallows both buttons; run beats step.
                if (bus.cpu_halted) begin
                    state_d = S_HALT;
                end else if (run_press) begin
                    state_d = S_RUN;
                end else if (step_press) begin
                    state_d  = S_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
            end
            S_RUN: begin
                // Halting (by CPU or button) suppresses a coincident tick.
                if (bus.cpu_halted) begin
                    state_d = S_HALT;
                end else if (run_press) begin
                    state_d = S_HALT;
                end else if (bus.tick) begin
                    cpu_en_d = 1'b1;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        running_d = (state_d == S_RUN);
        // Counts the pulse currently on cpu_en; visible one cycle later.
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, cpu_en_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HALT;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.running    = running_q;
    assign bus.step_count = cnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed self-checking bench for step_ctrl with
// DEBOUNCE_CYCLES=4, CNT_W=4 and a tick every 10 cycles.
module tb_step_ctrl;

    logic clk;
    logic rst;

    step_ctrl_if #(.CNT_W(4)) bus ();

    step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    bit   tick_en = 1'b0;
    int   pulses = 0;
    int   b2b = 0;
    bit   prev_en = 1'b0;
    bit   running_seen = 1'b0;
    int   base;
    logic [3:0] exp_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s got %0d", tag, got);
        end
    endtask

    // One clock: wait for the edge, settle, record outputs, then set the
    // tick for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.cpu_en) pulses++;
        if (bus.cpu_en && prev_en) b2b++;
        prev_en = bus.cpu_en;
        if (bus.running) running_seen = 1'b1;
        cyc_cnt++;
        bus.tick = tick_en && (cyc_cnt % 10 == 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Advance until the tick is set up for the next edge.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.tick && n < 30);
        if (!bus.tick) check_val("tick_timeout", 32'd0, 32'd1);
    endtask

    // Hold a button for hold cycles, then release and let it settle.
    task automatic press_run(input int hold, input int settle);
        bus.btn_run = 1'b1;
        cycles(hold);
        bus.btn_run = 1'b0;
        cycles(settle);
    endtask

    task automatic press_step(input int hold, input int settle);
        bus.btn_step = 1'b1;
        cycles(hold);
        bus.btn_step = 1'b0;
        cycles(settle);
    endtask

    initial begin
        rst            = 1'b1;
        bus.tick       = 1'b0;
        bus.btn_run    = 1'b0;
        bus.btn_step   = 1'b0;
        bus.cpu_halted = 1'b0;
        #12;
        rst = 1'b0;
        #1;
        check_val("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check_val("rst_running", 32'(bus.running), 32'd0);
        check_val("rst_count", 32'(bus.step_count), 32'd0);

        // 1: idle with ticks, nothing happens
        tick_en = 1'b1;
        cycles(50);
        check_val("idle_pulses", 32'(pulses), 32'd0);
        check_val("idle_running", 32'(bus.running), 32'd0);
        check_val("idle_count", 32'(bus.step_count), 32'd0);

        // 2: run button, exact latency, then 3 ticks
        tick_en = 1'b0;
        cyc();
        bus.btn_run = 1'b1;
        cycles(7);
        check_val("run_edge7", 32'(bus.running), 32'd0);
        cyc();
        check_val("run_edge8", 32'(bus.running), 32'd1);
        cycles(12);
        bus.btn_run = 1'b0;
        cycles(15);
        check_val("run_pre_count", 32'(bus.step_count), 32'd0);
        tick_en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_tick();
            cyc();
            check_val("run_tick_en", 32'(bus.cpu_en), 32'd1);
            cyc();
            check_val("run_tick_off", 32'(bus.cpu_en), 32'd0);
        end
        check_val("run_count3", 32'(bus.step_count), 32'd3);

        // 3: cpu_halted drops RUN; ticks and steps ignored
        bus.cpu_halted = 1'b1;
        base = pulses;
        cyc();
        check_val("halted_running", 32'(bus.running), 32'd0);
        press_step(10, 30);
        check_val("halted_pulses", 32'(pulses - base), 32'd0);
        check_val("halted_running2", 32'(bus.running), 32'd0);
        bus.cpu_halted = 1'b0;
        cycles(3);

        // 4: three clean step presses, then a 3-cycle bounce
        base = pulses;
        running_seen = 1'b0;
        bus.btn_step = 1'b1;
        cycles(7);
        check_val("step_edge7", 32'(bus.cpu_en), 32'd0);
        cyc();
        check_val("step_edge8", 32'(bus.cpu_en), 32'd1);
        cyc();
        check_val("step_edge9", 32'(bus.cpu_en), 32'd0);
        cyc();
        bus.btn_step = 1'b0;
        cycles(12);
        press_step(10, 12);
        press_step(10, 12);
        check_val("step_pulses3", 32'(pulses - base), 32'd3);
        press_step(3, 20);
        check_val("bounce_pulses", 32'(pulses - base), 32'd3);
        check_val("step_running", 32'(running_seen), 32'd0);
        check_val("step_count6", 32'(bus.step_count), 32'd6);

        // 5: 17 ticks with wrap, then run_press coinciding with a tick
        tick_en = 1'b0;
        press_run(10, 15);
        check_val("run2_running", 32'(bus.running), 32'd1);
        exp_cnt = 4'd6;
        check_val("wrap_start", 32'(bus.step_count), 32'(exp_cnt));
        tick_en = 1'b1;
        for (int t = 0; t < 17; t++) begin
            wait_tick();
            cyc();
            cyc();
            exp_cnt = exp_cnt + 4'd1;
            check_val("wrap_count", 32'(bus.step_count), 32'(exp_cnt));
        end
        // tick now set for the next edge (call c+1); the one after is
        // sampled in call c+11, which must be press edge 8 (call k+8).
        wait_tick();
        cycles(3);
        bus.btn_run = 1'b1;
        cycles(7);
        base = pulses;
        cyc();
        check_val("align_cpu_en", 32'(bus.cpu_en), 32'd0);
        check_val("align_running", 32'(bus.running), 32'd0);
        cycles(2);
        bus.btn_run = 1'b0;
        cycles(15);
        check_val("align_pulses", 32'(pulses - base), 32'd0);

        // 6: asynchronous reset while cpu_en is high
        tick_en = 1'b0;
        press_run(10, 15);
        tick_en = 1'b1;
        wait_tick();
        cyc();
        check_val("pre_rst_cpu_en", 32'(bus.cpu_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check_val("arst_running", 32'(bus.running), 32'd0);
        check_val("arst_count", 32'(bus.step_count), 32'd0);
        #2;
        rst = 1'b0;
        prev_en = 1'b0;
        base = pulses;
        cycles(30);
        check_val("post_rst_pulses", 32'(pulses - base), 32'd0);
        check_val("post_rst_running", 32'(bus.running), 32'd0);
        check_val("post_rst_count", 32'(bus.step_count), 32'd0);

        check_val("no_back_to_back", 32'(b2b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Run/step controller that sits directly downstream of the slow clock-enable divider in the minicpu top level. It consumes the divider's one-cycle `tick` pulse and two raw push-buttons, and issues one-cycle `cpu_en` pulses that advance the CPU by one instruction. It supports free-running at tick rate, halting, and single-stepping. It also counts the steps issued, for display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz). Legal values are ≥ 2.
- `CNT_W`, default 16: width of `step_count`.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset. Asynchronous, active-high. Same port name as the rest of the codebase.
- `tick` in 1: one-cycle pulse from the slow clock divider, synchronous to `clk`.
- `btn_run` in 1: raw run/halt toggle button, asynchronous to `clk`, active-high.
- `btn_step` in 1: raw single-step button, asynchronous to `clk`, active-high.
- `cpu_halted` in 1: CPU has executed HALT. Synchronous level.
- `cpu_en` out 1: one-cycle advance pulse to the CPU. Registered.
- `running` out 1: high while the FSM is in RUN. Registered.
- `step_count` out `CNT_W`: number of `cpu_en` pulses issued since reset. Registered.

## Operation
Button path (one instance per button):
- Two-flop synchronizer produces `s2`.
- Debounced level `db`, with counter `dcnt` of width $clog2(DEBOUNCE_CYCLES).
- If `s2 == db`: `dcnt <= 0`.
- Else if `dcnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `dcnt <= 0`.
- Else: `dcnt <= dcnt+1`.
- Press pulse `*_press` is registered, high for one cycle when `db` rises. Release generates nothing.

FSM states: HALT (reset state), RUN, STEP. Transitions are listed in priority order.
- HALT:
  - `cpu_halted` → stay; both presses are ignored.
  - `run_press` → RUN.
  - `step_press` → STEP.
- STEP:
  - Unconditionally back to HALT next cycle.
  - Entering STEP sets `cpu_en` to 1 for exactly that one cycle.
- RUN:
  - `cpu_halted` → HALT, no `cpu_en`.
  - Else `run_press` → HALT, no `cpu_en`, even if `tick` is high the same cycle.
  - Else `tick` → stay; `cpu_en` is high the next cycle.
  - `step_press` is ignored in RUN.
- `run_press` and `step_press` in the same cycle while in HALT: run wins.

Outputs and counter:
- `cpu_en` is never high on two consecutive cycles from STEP. In RUN it follows `tick`, which the divider guarantees is never back-to-back.
- `step_count` increments in the cycle `cpu_en` is high and becomes visible the following cycle. It wraps from all-ones to 0 with no flag.
- `running` = (state == RUN), registered together with the state.

## Timing
- Reset values: state HALT, `cpu_en` 0, `running` 0, `step_count` 0. All synchronizer, `db` and `dcnt` registers reset to 0.
- Reset is asserted asynchronously: outputs drop immediately, mid-run or mid-debounce. Release takes effect on the next `clk` edge.
- Tick latency: `tick` sampled high at edge N in RUN gives `cpu_en` high during cycle N+1 only.
- Button latency, counting edge 1 as the first edge sampling a new stable raw level:
  - `s2` changes at edge 2.
  - `db` changes at edge DEBOUNCE_CYCLES+2.
  - `*_press` is high after edge DEBOUNCE_CYCLES+3.
  - The FSM changes state at edge DEBOUNCE_CYCLES+4.
- A glitch shorter than DEBOUNCE_CYCLES cycles at `s2` produces no press.
- Step latency: `step_press` high in HALT gives `cpu_en` high one cycle later, then HALT one cycle after that.
- `cpu_halted` takes effect at the edge where it is sampled.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=4, with the bench pulsing `tick` every 10 cycles.
1. Reset then idle 50 cycles → `cpu_en` stays 0, `running` 0, `step_count` 0.
2. Hold `btn_run` high 20 cycles → `running` rises 8 edges after the first sampling edge. Each subsequent `tick` produces exactly one `cpu_en` one cycle later. After 3 ticks, `step_count` = 3.
3. In RUN, raise `cpu_halted` → `running` falls at the next edge. Further ticks and `btn_step` presses give no `cpu_en`.
4. From HALT, three clean `btn_step` presses, each held 10 cycles → exactly three single-cycle `cpu_en` pulses with `running` staying 0. Bounce `btn_step` high for 3 cycles → no pulse.
5. In RUN, 17 ticks → `step_count` goes 15 → 0 (wrap). Align the `run_press` cycle with a `tick` → HALT with no `cpu_en`.
6. Assert `rst` asynchronously mid-cycle while `cpu_en` = 1 → `cpu_en`, `running` and `step_count` clear immediately. After release the FSM is in HALT and requires a fresh press.
